// File: rtl/alu_multiword_seq.sv
// Multi-word sequencer for alu64bit: streams WORDS operand slices through one
// WIDTH-bit ALU, least significant word first, chaining carry between words.
module alu_multiword_seq #(
  parameter int WIDTH = 64,
  parameter int WORDS = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               op_in,
  input  logic                     cin_in,
  input  logic [WORDS*WIDTH-1:0]   a_in,
  input  logic [WORDS*WIDTH-1:0]   b_in,
  output logic                     busy,
  output logic                     done,
  output logic [WORDS*WIDTH-1:0]   result,
  output logic                     cout_out,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic                     alu_cin,
  output logic [1:0]               alu_op,
  input  logic [WIDTH-1:0]         alu_s,
  input  logic                     alu_cout
);

  localparam int TOTAL = WORDS * WIDTH;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q;
  logic [TOTAL-1:0]   a_q, b_q;
  logic [1:0]         op_q;
  logic               cin_q;
  logic               carry_q;
  logic [TOTAL-1:0]   result_q;
  logic               cout_q;
  logic               done_q;

  logic               accept;
  logic               running;
  logic               last_word;
  logic [WIDTH-1:0]   word_a, word_b;

  assign running   = (state_q == RUN);
  assign accept    = (state_q == IDLE) && start;
  assign last_word = (idx_q == IDX_W'(WORDS - 1));

  // Next-state logic.
  // NOTE: every signal written in an always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)     state_d = RUN;
      RUN:     if (last_word) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Select the operand slice for the current word index.
  always_comb begin
    word_a = '0;
    word_b = '0;
    for (int w = 0; w < WORDS; w++) begin
      if (idx_q == IDX_W'(w)) begin
        word_a = a_q[w*WIDTH +: WIDTH];
        word_b = b_q[w*WIDTH +: WIDTH];
      end
    end
  end

  // ALU drive: quiet zeros while idle, current word while running.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_op  = 2'b00;
    if (running) begin
      alu_a   = word_a;
      alu_b   = word_b;
      alu_op  = op_q;
      alu_cin = (idx_q == '0) ? cin_q : carry_q;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= 2'b00;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= 1'b0;

      if (accept) begin
        a_q   <= a_in;
        b_q   <= b_in;
        op_q  <= op_in;
        cin_q <= cin_in;
        idx_q <= '0;
      end

      if (running) begin
        for (int w = 0; w < WORDS; w++) begin
          if (idx_q == IDX_W'(w)) result_q[w*WIDTH +: WIDTH] <= alu_s;
        end
        carry_q <= alu_cout;
        if (last_word) begin
          cout_q <= alu_cout;
          done_q <= 1'b1;
          idx_q  <= '0;
        end else begin
          idx_q <= idx_q + 1'b1;
        end
      end
    end
  end

  assign busy     = running;
  assign done     = done_q;
  assign result   = result_q;
  assign cout_out = cout_q;

endmodule

// File: tb/tb_alu_multiword_seq.sv
// Directed bench for alu_multiword_seq (WORDS=2, WIDTH=64) with a behavioural
// alu64bit stand-in: op 0 add, 1 subtract (a + ~b + cin), 2 and, 3 xor.
module tb_alu_multiword_seq;

  localparam int WIDTH = 64;
  localparam int WORDS = 2;
  localparam int TOTAL = WORDS * WIDTH;
  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_AND = 2'd2;
  localparam logic [1:0] OP_XOR = 2'd3;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [1:0]       op_in = 2'b00;
  logic             cin_in = 1'b0;
  logic [TOTAL-1:0] a_in = '0;
  logic [TOTAL-1:0] b_in = '0;
  logic             busy, done, cout_out;
  logic [TOTAL-1:0] result;
  logic [WIDTH-1:0] alu_a, alu_b, alu_s;
  logic             alu_cin, alu_cout;
  logic [1:0]       alu_op;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_multiword_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .start(start), .op_in(op_in), .cin_in(cin_in),
    .a_in(a_in), .b_in(b_in), .busy(busy), .done(done), .result(result),
    .cout_out(cout_out), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_op(alu_op), .alu_s(alu_s), .alu_cout(alu_cout)
  );

  // Combinational ALU stand-in.
  always_comb begin
    alu_s    = '0;
    alu_cout = 1'b0;
    case (alu_op)
      2'd0: {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, alu_b} + 65'(alu_cin);
      2'd1: {alu_cout, alu_s} = {1'b0, alu_a} + {1'b0, ~alu_b} + 65'(alu_cin);
      2'd2: begin alu_s = alu_a & alu_b; alu_cout = alu_cin; end
      default: begin alu_s = alu_a ^ alu_b; alu_cout = alu_cin; end
    endcase
  end

  task automatic check(input string tag, input logic [TOTAL-1:0] got,
                       input logic [TOTAL-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Full-width reference: one wide operation; logic ops pass cin through.
  task automatic model(input logic [TOTAL-1:0] a, b, input logic [1:0] op,
                       input logic cin, output logic [TOTAL-1:0] r,
                       output logic co, output logic c0);
    logic [TOTAL:0]   wide;
    logic [WIDTH:0]   low;
    wide = '0;
    low  = '0;
    r    = '0;
    co   = cin;
    c0   = cin;
    case (op)
      OP_ADD: begin
        wide = {1'b0, a} + {1'b0, b} + (TOTAL+1)'(cin);
        low  = {1'b0, a[WIDTH-1:0]} + {1'b0, b[WIDTH-1:0]} + (WIDTH+1)'(cin);
        r = wide[TOTAL-1:0]; co = wide[TOTAL]; c0 = low[WIDTH];
      end
      OP_SUB: begin
        wide = {1'b0, a} + {1'b0, ~b} + (TOTAL+1)'(cin);
        low  = {1'b0, a[WIDTH-1:0]} + {1'b0, ~b[WIDTH-1:0]} + (WIDTH+1)'(cin);
        r = wide[TOTAL-1:0]; co = wide[TOTAL]; c0 = low[WIDTH];
      end
      OP_AND:  r = a & b;
      default: r = a ^ b;
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete operation with latency, pass-through and pulse-width checks.
  task automatic run_op(input string tag, input logic [TOTAL-1:0] a, b,
                        input logic [1:0] op, input logic cin);
    logic [TOTAL-1:0] exp_r;
    logic             exp_c, exp_c0;
    model(a, b, op, cin, exp_r, exp_c, exp_c0);
    a_in = a; b_in = b; op_in = op; cin_in = cin; start = 1'b1;
    tick();
    start = 1'b0;
    a_in = ~a; b_in = ~b; op_in = ~op; cin_in = ~cin;
    check({tag, " busy w0"}, TOTAL'(busy), TOTAL'(1'b1));
    check({tag, " op w0"},   TOTAL'(alu_op), TOTAL'(op));
    check({tag, " a w0"},    TOTAL'(alu_a), TOTAL'(a[WIDTH-1:0]));
    check({tag, " b w0"},    TOTAL'(alu_b), TOTAL'(b[WIDTH-1:0]));
    check({tag, " cin w0"},  TOTAL'(alu_cin), TOTAL'(cin));
    tick();
    check({tag, " op w1"},   TOTAL'(alu_op), TOTAL'(op));
    check({tag, " a w1"},    TOTAL'(alu_a), TOTAL'(a[TOTAL-1:WIDTH]));
    check({tag, " cin w1"},  TOTAL'(alu_cin), TOTAL'(exp_c0));
    check({tag, " done early"}, TOTAL'(done), '0);
    tick();
    check({tag, " done"},    TOTAL'(done), TOTAL'(1'b1));
    check({tag, " busy end"}, TOTAL'(busy), '0);
    check({tag, " result"},  result, exp_r);
    check({tag, " cout"},    TOTAL'(cout_out), TOTAL'(exp_c));
    tick();
    check({tag, " done width"}, TOTAL'(done), '0);
    check({tag, " result hold"}, result, exp_r);
  endtask

  logic [TOTAL-1:0] r1, r2;
  logic             c1, c2, cx;

  initial begin
    // Reset
    rst = 1'b1;
    tick(); tick();
    check("rst busy",   TOTAL'(busy), '0);
    check("rst done",   TOTAL'(done), '0);
    check("rst result", result, '0);
    check("rst cout",   TOTAL'(cout_out), '0);
    check("rst alu_a",  TOTAL'(alu_a), '0);
    check("rst alu_b",  TOTAL'(alu_b), '0);
    rst = 1'b0;
    tick();

    // Carry chain across the word boundary: result {2,0}, cout 0
    run_op("chain", {64'h1, 64'hFFFF_FFFF_FFFF_FFFF}, {64'h0, 64'h1}, OP_ADD, 1'b0);
    check("chain const", result, {64'h2, 64'h0});

    // Final carry out: all ones + 0 + 1 = 0, cout 1
    run_op("cout", {TOTAL{1'b1}}, '0, OP_ADD, 1'b1);
    check("cout const", {result[TOTAL-2:0], cout_out}, TOTAL'(1'b1));

    // Busy ignore then back-to-back accept in the done cycle
    model({64'h5, 64'h8000_0000_0000_0000}, {64'h6, 64'h8000_0000_0000_0000},
          OP_ADD, 1'b0, r1, c1, cx);
    model({64'hFFFF_FFFF_FFFF_FFFF, 64'h0}, {64'h0, 64'h1}, OP_SUB, 1'b1, r2, c2, cx);
    a_in = {64'h5, 64'h8000_0000_0000_0000};
    b_in = {64'h6, 64'h8000_0000_0000_0000};
    op_in = OP_ADD; cin_in = 1'b0; start = 1'b1;
    tick();
    a_in = '1; b_in = '1; op_in = OP_XOR;
    check("b2b busy0", TOTAL'(busy), TOTAL'(1'b1));
    tick();
    check("b2b no done0", TOTAL'(done), '0);
    check("b2b busy1", TOTAL'(busy), TOTAL'(1'b1));
    tick();
    check("b2b done1", TOTAL'(done), TOTAL'(1'b1));
    check("b2b res1", result, r1);
    check("b2b cout1", TOTAL'(cout_out), TOTAL'(c1));
    a_in = {64'hFFFF_FFFF_FFFF_FFFF, 64'h0}; b_in = {64'h0, 64'h1};
    op_in = OP_SUB; cin_in = 1'b1;
    tick();
    start = 1'b0;
    check("b2b accept2", TOTAL'(busy), TOTAL'(1'b1));
    check("b2b single done", TOTAL'(done), '0);
    tick();
    check("b2b no done2a", TOTAL'(done), '0);
    tick();
    check("b2b done2", TOTAL'(done), TOTAL'(1'b1));
    check("b2b res2", result, r2);
    check("b2b cout2", TOTAL'(cout_out), TOTAL'(c2));
    tick();
    check("b2b done2 width", TOTAL'(done), '0);

    // Reset during the word-1 cycle
    a_in = {64'h7, 64'h9}; b_in = {64'h3, 64'h4}; op_in = OP_ADD; cin_in = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("abort in w1", TOTAL'(busy), TOTAL'(1'b1));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort busy",   TOTAL'(busy), '0);
    check("abort done",   TOTAL'(done), '0);
    check("abort result", result, '0);
    check("abort cout",   TOTAL'(cout_out), '0);
    tick();
    check("abort no done", TOTAL'(done), '0);
    tick();
    check("abort no done2", TOTAL'(done), '0);
    run_op("after abort", {64'h7, 64'h9}, {64'h3, 64'h4}, OP_ADD, 1'b0);

    // Opcode pass-through over all encodings
    run_op("op0", {64'h0123_4567_89AB_CDEF, 64'hFFFF_0000_FFFF_0000},
           {64'h1111_1111_1111_1111, 64'h0001_0000_0001_0000}, 2'd0, 1'b1);
    run_op("op1", {64'h0, 64'h5}, {64'h0, 64'h7}, 2'd1, 1'b1);
    run_op("op2", {64'hF0F0_F0F0_F0F0_F0F0, 64'hAAAA_5555_AAAA_5555},
           {64'hFF00_FF00_FF00_FF00, 64'h0FF0_0FF0_0FF0_0FF0}, 2'd2, 1'b1);
    run_op("op3", {64'hDEAD_BEEF_DEAD_BEEF, 64'h1234_5678_9ABC_DEF0},
           {64'hFFFF_FFFF_0000_0000, 64'h0F0F_0F0F_0F0F_0F0F}, 2'd3, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
